// File: rtl/apb_uart_arb_pkg.sv
// Shared types and constants for the APB UART print arbiter.
package apb_uart_arb_pkg;

   // Arbiter transaction phases toward the shared UART
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } arb_state_e;

   localparam logic [7:0]  DefNewlineChar = 8'h0A;
   localparam logic [31:0] DefThrOffset   = 32'h0000_0000;

   // Width of an index into n requesters; never narrower than one bit
   function automatic int idx_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/apb_uart_arb_rr_picker.sv
// Combinational masked round-robin picker: searches the masked request vector
// starting one past the previous winner and wrapping once around.
module apb_uart_arb_rr_picker
   import apb_uart_arb_pkg::*;
#(
   parameter int NumReq = 4
) (
   input  logic [NumReq-1:0]                 req_i,
   input  logic [NumReq-1:0]                 mask_i,
   input  logic [idx_width(NumReq)-1:0]      last_i,
   output logic                              valid_o,
   output logic [idx_width(NumReq)-1:0]      idx_o
);

   localparam int IdxW = idx_width(NumReq);

   logic [NumReq-1:0] cand_s;
   logic [IdxW-1:0]   pos_s;

   assign cand_s = req_i & mask_i;

   // First eligible candidate after last_i wins; last_i itself is checked last
   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      pos_s   = '0;
      for (int i = 1; i <= NumReq; i++) begin
         pos_s = IdxW'((int'(last_i) + i) % NumReq);
         if (!valid_o && cand_s[pos_s]) begin
            valid_o = 1'b1;
            idx_o   = pos_s;
         end else begin
            valid_o = valid_o;
            idx_o   = idx_o;
         end
      end
   end

endmodule

// File: rtl/apb_uart_print_arbiter.sv
// Shares one mock UART APB slave between several APB requesters. A write of a
// printable character to the THR locks the UART to that requester until it
// writes the newline, so lines from different cores never interleave. An
// owner that goes quiet loses the lock after LockTimeout idle cycles.
module apb_uart_print_arbiter
   import apb_uart_arb_pkg::*;
#(
   parameter int          NumReq      = 4,
   parameter int          AddrWidth   = 32,
   parameter int          LockTimeout = 1024,
   parameter logic [31:0] ThrOffset   = DefThrOffset,
   parameter logic [7:0]  NewlineChar = DefNewlineChar
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [NumReq-1:0]                psel_i,
   input  logic [NumReq-1:0]                penable_i,
   input  logic [NumReq-1:0]                pwrite_i,
   input  logic [NumReq-1:0][AddrWidth-1:0] paddr_i,
   input  logic [NumReq-1:0][31:0]          pwdata_i,
   output logic [NumReq-1:0][31:0]          prdata_o,
   output logic [NumReq-1:0]                pready_o,
   output logic [NumReq-1:0]                pslverr_o,
   output logic                             psel_o,
   output logic                             penable_o,
   output logic                             pwrite_o,
   output logic [AddrWidth-1:0]             paddr_o,
   output logic [31:0]                      pwdata_o,
   input  logic [31:0]                      prdata_i,
   input  logic                             pready_i,
   input  logic                             pslverr_i,
   output logic                             lock_active_o,
   output logic [$clog2(NumReq)-1:0]        lock_idx_o
);

   localparam int              IdxW       = idx_width(NumReq);
   localparam int              CntW       = $clog2(LockTimeout + 1);
   localparam logic [CntW-1:0] TimeoutMax = CntW'(LockTimeout - 1);
   localparam logic [CntW-1:0] CntOne     = CntW'(1);

   arb_state_e           state_q, state_d;
   logic [IdxW-1:0]      gidx_q, gidx_d;
   logic [IdxW-1:0]      last_q, last_d;
   logic                 pwrite_q, pwrite_d;
   logic [AddrWidth-1:0] paddr_q, paddr_d;
   logic [31:0]          pwdata_q, pwdata_d;
   logic [31:0]          prdata_q, prdata_d;
   logic                 pslverr_q, pslverr_d;
   logic                 lock_q, lock_d;
   logic [IdxW-1:0]      lock_idx_q, lock_idx_d;
   logic [CntW-1:0]      cnt_q, cnt_d;

   logic                 owner_idle_s;
   logic                 timeout_s;
   logic [NumReq-1:0]    mask_s;
   logic                 pick_valid_s;
   logic [IdxW-1:0]      pick_idx_s;
   logic                 resp_hs_s;
   logic                 thr_hit_s;

   // Idle-owner timeout and the request mask applied to arbitration this cycle;
   // a timeout drops the mask immediately so the same cycle arbitrates freely
   always_comb begin
      owner_idle_s = lock_q && (state_q == ST_IDLE) && !psel_i[lock_idx_q];
      timeout_s    = owner_idle_s && (cnt_q == TimeoutMax);
      mask_s       = {NumReq{1'b1}};
      if (lock_q && !timeout_s) begin
         mask_s             = '0;
         mask_s[lock_idx_q] = 1'b1;
      end else begin
         mask_s = {NumReq{1'b1}};
      end
   end

   apb_uart_arb_rr_picker #(
      .NumReq (NumReq)
   ) u_picker (
      .req_i   (psel_i),
      .mask_i  (mask_s),
      .last_i  (last_q),
      .valid_o (pick_valid_s),
      .idx_o   (pick_idx_s)
   );

   // Next-state logic for the transfer FSM, captured fields and line lock
   always_comb begin
      state_d    = state_q;
      gidx_d     = gidx_q;
      last_d     = last_q;
      pwrite_d   = pwrite_q;
      paddr_d    = paddr_q;
      pwdata_d   = pwdata_q;
      prdata_d   = prdata_q;
      pslverr_d  = pslverr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      cnt_d      = cnt_q;
      resp_hs_s  = 1'b0;
      thr_hit_s  = (paddr_q[7:0] == ThrOffset[7:0]);
      case (state_q)
         ST_IDLE: begin
            // Reaching TimeoutMax always fires the timeout, so the
            // increment below can never wrap
            if (timeout_s) begin
               lock_d = 1'b0;
               cnt_d  = '0;
            end else if (pick_valid_s && lock_q && (pick_idx_s == lock_idx_q)) begin
               cnt_d = '0;
            end else if (owner_idle_s) begin
               cnt_d = cnt_q + CntOne;
            end else begin
               cnt_d = cnt_q;
            end
            if (pick_valid_s) begin
               gidx_d   = pick_idx_s;
               last_d   = pick_idx_s;
               pwrite_d = pwrite_i[pick_idx_s];
               paddr_d  = paddr_i[pick_idx_s];
               pwdata_d = pwdata_i[pick_idx_s];
               state_d  = ST_SETUP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (pready_i) begin
               prdata_d  = prdata_i;
               pslverr_d = pslverr_i;
               state_d   = ST_RESP;
            end else begin
               state_d = ST_ACCESS;
            end
         end
         ST_RESP: begin
            if (!psel_i[gidx_q]) begin
               // Requester abandoned the transfer: drop the response
               state_d = ST_IDLE;
            end else if (penable_i[gidx_q]) begin
               resp_hs_s = 1'b1;
               state_d   = ST_IDLE;
               if (pwrite_q && thr_hit_s) begin
                  if (pwdata_q[7:0] == NewlineChar) begin
                     lock_d = 1'b0;
                     cnt_d  = '0;
                  end else begin
                     lock_d     = 1'b1;
                     lock_idx_d = gidx_q;
                     cnt_d      = '0;
                  end
               end else begin
                  lock_d = lock_q;
               end
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Granted index, round-robin pointer, request fields and UART response
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         gidx_q    <= '0;
         last_q    <= '0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= 32'h0000_0000;
         prdata_q  <= 32'h0000_0000;
         pslverr_q <= 1'b0;
      end else begin
         gidx_q    <= gidx_d;
         last_q    <= last_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
      end
   end

   // Line lock owner and idle timeout counter
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         cnt_q      <= '0;
      end else begin
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         cnt_q      <= cnt_d;
      end
   end

   // UART-side strobes decode from state; the response is routed only to the
   // granted requester during its handshake cycle
   always_comb begin
      psel_o    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
      penable_o = (state_q == ST_ACCESS);
      pready_o  = '0;
      prdata_o  = '0;
      pslverr_o = '0;
      if (resp_hs_s) begin
         pready_o[gidx_q]  = 1'b1;
         prdata_o[gidx_q]  = prdata_q;
         pslverr_o[gidx_q] = pslverr_q;
      end else begin
         pready_o  = '0;
         prdata_o  = '0;
         pslverr_o = '0;
      end
   end

   assign pwrite_o      = pwrite_q;
   assign paddr_o       = paddr_q;
   assign pwdata_o      = pwdata_q;
   assign lock_active_o = lock_q;
   assign lock_idx_o    = lock_idx_q;

endmodule

// File: tb/tb_apb_uart_print_arbiter.sv
// Directed bench for apb_uart_print_arbiter: four APB requester models, a
// configurable mock UART and hand-computed grant order / latency checks.
module tb_apb_uart_print_arbiter;

   logic            clk;
   logic            rst;
   logic [3:0]      psel_i, penable_i, pwrite_i;
   logic [3:0][31:0] paddr_i, pwdata_i;
   logic [3:0][31:0] prdata_o;
   logic [3:0]      pready_o, pslverr_o;
   logic            psel_o, penable_o, pwrite_o;
   logic [31:0]     paddr_o, pwdata_o;
   logic [31:0]     prdata_i;
   logic            pready_i, pslverr_i;
   logic            lock_active_o;
   logic [1:0]      lock_idx_o;

   typedef struct {
      int          port;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   typedef struct {
      int          port;
      logic [31:0] rdata;
      logic        err;
      int          start;
      int          done;
   } cmp_t;

   txn_t pend[$];
   cmp_t comp[$];
   int   cyc;
   int   wait_cfg;
   int   n_cmp;
   int   n_bad;

   apb_uart_print_arbiter #(
      .NumReq      (4),
      .AddrWidth   (32),
      .LockTimeout (16),
      .ThrOffset   (32'h0000_0000),
      .NewlineChar (8'h0A)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .psel_i        (psel_i),
      .penable_i     (penable_i),
      .pwrite_i      (pwrite_i),
      .paddr_i       (paddr_i),
      .pwdata_i      (pwdata_i),
      .prdata_o      (prdata_o),
      .pready_o      (pready_o),
      .pslverr_o     (pslverr_o),
      .psel_o        (psel_o),
      .penable_o     (penable_o),
      .pwrite_o      (pwrite_o),
      .paddr_o       (paddr_o),
      .pwdata_o      (pwdata_o),
      .prdata_i      (prdata_i),
      .pready_i      (pready_i),
      .pslverr_i     (pslverr_i),
      .lock_active_o (lock_active_o),
      .lock_idx_o    (lock_idx_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input int port, input bit wr, input logic [31:0] addr, input logic [31:0] data);
      txn_t t;
      t.port = port; t.wr = wr; t.addr = addr; t.data = data;
      pend.push_back(t);
   endtask

   function automatic cmp_t get_comp(input int idx);
      cmp_t c;
      c.port = -1; c.rdata = 32'hFFFF_FFFF; c.err = 1'b1; c.start = 0; c.done = -1000;
      if (idx < comp.size()) c = comp[idx];
      return c;
   endfunction

   task automatic wait_comp(input string tag, input int n);
      int guard;
      guard = 0;
      while (comp.size() < n && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check_eq({tag, "_done"}, comp.size(), n);
   endtask

   // Requester models and mock UART: sample at negedge, drive 1ns after posedge
   initial begin
      int          phase[4];
      int          start_c[4];
      logic        seen_rdy[4];
      logic [31:0] seen_data[4];
      logic        seen_err[4];
      logic        acc_seen, rdy_was;
      int          seen_c, wcnt, found;
      cmp_t        c;
      psel_i = '0; penable_i = '0; pwrite_i = '0; paddr_i = '0; pwdata_i = '0;
      pready_i = 1'b1; wcnt = 0;
      for (int p = 0; p < 4; p++) begin phase[p] = 0; start_c[p] = 0; end
      forever begin
         @(negedge clk);
         for (int p = 0; p < 4; p++) begin
            seen_rdy[p] = pready_o[p]; seen_data[p] = prdata_o[p]; seen_err[p] = pslverr_o[p];
         end
         acc_seen = psel_o && penable_o;
         rdy_was  = pready_i;
         seen_c   = cyc;
         @(posedge clk);
         #1;
         if (rst) begin
            for (int p = 0; p < 4; p++) phase[p] = 0;
            psel_i = '0; penable_i = '0;
            wcnt = 0;
            pready_i = (wait_cfg == 0);
         end else begin
            for (int p = 0; p < 4; p++) begin
               if (phase[p] == 2 && seen_rdy[p]) begin
                  c.port = p; c.rdata = seen_data[p]; c.err = seen_err[p];
                  c.start = start_c[p]; c.done = seen_c;
                  comp.push_back(c);
                  phase[p] = 0; psel_i[p] = 1'b0; penable_i[p] = 1'b0;
               end
               if (phase[p] == 1) begin
                  penable_i[p] = 1'b1;
                  phase[p] = 2;
               end else if (phase[p] == 0) begin
                  found = -1;
                  for (int k = 0; k < pend.size(); k++) begin
                     if (found < 0 && pend[k].port == p) found = k;
                  end
                  if (found >= 0) begin
                     psel_i[p] = 1'b1; penable_i[p] = 1'b0;
                     pwrite_i[p] = pend[found].wr;
                     paddr_i[p] = pend[found].addr;
                     pwdata_i[p] = pend[found].data;
                     pend.delete(found);
                     start_c[p] = cyc;
                     phase[p] = 1;
                  end
               end
            end
            if (acc_seen && !rdy_was) wcnt++;
            else wcnt = 0;
            pready_i = (wcnt >= wait_cfg);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1);
   end

   initial begin
      cmp_t c, c2;
      int   base, r, g, lock_clr;
      int   exp_order[6];
      n_cmp = 0; n_bad = 0; wait_cfg = 0;
      rst = 1'b1; prdata_i = 32'h1234_5678; pslverr_i = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_psel", {31'd0, psel_o}, 32'd0);
      check_eq("rst_pready", {28'd0, pready_o}, 32'd0);
      check_eq("rst_lock", {29'd0, lock_active_o, lock_idx_o}, 32'd0);
      check_eq("rst_paddr", paddr_o, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Requester 1 prints 'A': 3-cycle latency, takes the lock
      push(1, 1'b1, 32'h0000_0000, 32'h0000_0041);
      g = 0;
      while (!psel_o && g < 20) begin @(negedge clk); g++; end
      check_eq("t1_setup", {30'd0, psel_o, penable_o}, 32'd2);
      check_eq("t1_paddr", paddr_o, 32'h0000_0000);
      check_eq("t1_pwdata", pwdata_o, 32'h0000_0041);
      check_eq("t1_pwrite", {31'd0, pwrite_o}, 32'd1);
      wait_comp("t1", 1);
      c = get_comp(0);
      check_eq("t1_port", c.port, 32'd1);
      check_eq("t1_latency", c.done - c.start, 32'd3);
      check_eq("t1_lock", {29'd0, lock_active_o, lock_idx_o}, 32'b101);
      push(1, 1'b1, 32'h0000_0000, 32'h0000_000A);
      wait_comp("t1nl", 2);
      check_eq("t1_unlock", {31'd0, lock_active_o}, 32'd0);

      // Ports 0 and 2 read offset 0x14 continuously: strict alternation, no lock
      base = comp.size();
      for (int i = 0; i < 3; i++) begin
         push(0, 1'b0, 32'h0000_0014, 32'h0);
         push(2, 1'b0, 32'h0000_0014, 32'h0);
      end
      exp_order = '{2, 0, 2, 0, 2, 0};
      wait_comp("t2", base + 6);
      for (int i = 0; i < 6; i++) begin
         c = get_comp(base + i);
         check_eq($sformatf("t2_order%0d", i), c.port, exp_order[i]);
      end
      c = get_comp(base);
      check_eq("t2_rdata", c.rdata, 32'h1234_5678);
      check_eq("t2_err", {31'd0, c.err}, 32'd0);
      check_eq("t2_nolock", {31'd0, lock_active_o}, 32'd0);

      // Port 0 prints "Hi\n" while port 3 waits on a THR write
      base = comp.size();
      push(0, 1'b1, 32'h0000_0000, 32'h0000_0048);
      wait_comp("t3h", base + 1);
      check_eq("t3_lock0", {29'd0, lock_active_o, lock_idx_o}, 32'b100);
      push(0, 1'b1, 32'h0000_0000, 32'h0000_0069);
      push(0, 1'b1, 32'h0000_0000, 32'h0000_000A);
      push(3, 1'b1, 32'h0000_0000, 32'h0000_005A);
      push(3, 1'b1, 32'h0000_0000, 32'h0000_000A);
      wait_comp("t3", base + 5);
      check_eq("t3_ord1", get_comp(base + 1).port, 32'd0);
      check_eq("t3_ord2", get_comp(base + 2).port, 32'd0);
      check_eq("t3_ord3", get_comp(base + 3).port, 32'd3);
      check_eq("t3_ord4", get_comp(base + 4).port, 32'd3);
      check_eq("t3_gap", get_comp(base + 3).done - get_comp(base + 2).done, 32'd4);
      check_eq("t3_unlock", {31'd0, lock_active_o}, 32'd0);

      // Port 1 locks then goes silent; port 2 waits for the 16-cycle timeout
      base = comp.size();
      push(1, 1'b1, 32'h0000_0000, 32'h0000_0078);
      wait_comp("t4x", base + 1);
      r = get_comp(base).done;
      check_eq("t4_lock1", {29'd0, lock_active_o, lock_idx_o}, 32'b101);
      push(2, 1'b0, 32'h0000_0014, 32'h0);
      g = 0;
      while (lock_active_o && g < 40) begin @(negedge clk); g++; end
      lock_clr = cyc;
      check_eq("t4_clr_cycle", lock_clr - r, 32'd17);
      wait_comp("t4", base + 2);
      c = get_comp(base + 1);
      check_eq("t4_port", c.port, 32'd2);
      check_eq("t4_done_cycle", c.done - r, 32'd19);

      // Five UART wait states and an error response on a read
      base = comp.size();
      wait_cfg = 5; pslverr_i = 1'b1; prdata_i = 32'hDEAD_BEEF;
      push(3, 1'b0, 32'h0000_0014, 32'h0);
      wait_comp("t5", base + 1);
      c = get_comp(base);
      check_eq("t5_port", c.port, 32'd3);
      check_eq("t5_err", {31'd0, c.err}, 32'd1);
      check_eq("t5_rdata", c.rdata, 32'hDEAD_BEEF);
      check_eq("t5_latency", c.done - c.start, 32'd8);
      wait_cfg = 0; pslverr_i = 1'b0; prdata_i = 32'h1234_5678;
      @(negedge clk);

      // Reset while in ACCESS with a lock held
      base = comp.size();
      push(2, 1'b1, 32'h0000_0000, 32'h0000_0050);
      wait_comp("t6p", base + 1);
      check_eq("t6_lock2", {29'd0, lock_active_o, lock_idx_o}, 32'b110);
      wait_cfg = 5;
      push(2, 1'b1, 32'h0000_0000, 32'h0000_0051);
      g = 0;
      while (!(psel_o && penable_o) && g < 20) begin @(negedge clk); g++; end
      check_eq("t6_in_access", {30'd0, psel_o, penable_o}, 32'd3);
      rst = 1'b1;
      #1;
      check_eq("t6_rst_strobes", {29'd0, psel_o, penable_o, pwrite_o}, 32'd0);
      check_eq("t6_rst_pready", {28'd0, pready_o}, 32'd0);
      check_eq("t6_rst_lock", {29'd0, lock_active_o, lock_idx_o}, 32'd0);
      check_eq("t6_rst_pwdata", pwdata_o, 32'd0);
      pend.delete();
      wait_cfg = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      base = comp.size();
      push(0, 1'b0, 32'h0000_0014, 32'h0);
      wait_comp("t6", base + 1);
      c2 = get_comp(base);
      check_eq("t6_port", c2.port, 32'd0);
      check_eq("t6_latency", c2.done - c2.start, 32'd3);
      check_eq("t6_nolock", {31'd0, lock_active_o}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
